// File: rtl/gpu_pkg.sv
// Shared GPU draw-command definitions: default field widths, command struct, arbiter states.
package gpu_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int SPR_W = 6;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SPR_W-1:0] spr;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpu_draw_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr_i, wrapping modulo N.
module rr_pick
  import gpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  // Scanning from the far end lets the closest hit to ptr_i win; one spare bit holds ptr+k before wrap.
  always_comb begin
    logic [IW:0] idx;
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (req_i[idx[IW-1:0]]) begin
        grant_o = idx[IW-1:0];
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_draw_arbiter.sv
// Round-robin arbiter sharing the GPU draw-command port between requesters, with a
// registered output stage and frame-boundary drain.
//   state    | meaning
//   ST_IDLE  | no grant; pending frame close wins, else pick next requester
//   ST_BURST | owner streams commands until last or MAX_BURST accepts
//   ST_DRAIN | wait for the output register to empty, then ack the frame
module gpu_draw_arbiter #(
  parameter int N_REQ     = 4,
  parameter int X_W       = gpu_pkg::X_W,
  parameter int Y_W       = gpu_pkg::Y_W,
  parameter int SPR_W     = gpu_pkg::SPR_W,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_last_i,
  input  logic [N_REQ*X_W-1:0]      req_x_i,
  input  logic [N_REQ*Y_W-1:0]      req_y_i,
  input  logic [N_REQ*SPR_W-1:0]    req_spr_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [X_W-1:0]            cmd_x_o,
  output logic [Y_W-1:0]            cmd_y_o,
  output logic [SPR_W-1:0]          cmd_spr_o,
  output logic [$clog2(N_REQ)-1:0]  cmd_src_o,
  input  logic                      frame_start_i,
  output logic                      frame_done_o,
  output logic                      busy_o
);
  import gpu_pkg::*;

  localparam int IW = $clog2(N_REQ);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic           pick_any;
  logic [7:0]     burst_cnt_q, burst_cnt_d;
  logic           frame_pend_q, frame_pend_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [X_W-1:0]   cmd_x_q, cmd_x_d;
  logic [Y_W-1:0]   cmd_y_q, cmd_y_d;
  logic [SPR_W-1:0] cmd_spr_q, cmd_spr_d;
  logic [IW-1:0]    cmd_src_q, cmd_src_d;
  logic           out_free, accept;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  assign out_free = !cmd_valid_q || cmd_ready_i;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    frame_pend_d = frame_pend_q | frame_start_i;
    cmd_valid_d  = cmd_valid_q && !cmd_ready_i;
    cmd_x_d      = cmd_x_q;
    cmd_y_d      = cmd_y_q;
    cmd_spr_d    = cmd_spr_q;
    cmd_src_d    = cmd_src_q;
    req_ready_o  = '0;
    frame_done_o = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_pend_q) begin
          state_d = ST_DRAIN;
        end else if (pick_any) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        req_ready_o[owner_q] = out_free;
        accept = req_valid_i[owner_q] && out_free;
        if (accept) begin
          cmd_valid_d = 1'b1;
          cmd_x_d     = req_x_i[owner_q*X_W +: X_W];
          cmd_y_d     = req_y_i[owner_q*Y_W +: Y_W];
          cmd_spr_d   = req_spr_i[owner_q*SPR_W +: SPR_W];
          cmd_src_d   = owner_q;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (req_last_i[owner_q] || burst_cnt_q == 8'(MAX_BURST - 1)) begin
            rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // A frame_start landing on the acknowledge cycle opens the next pending frame.
        if (!cmd_valid_q) begin
          frame_done_o = 1'b1;
          frame_pend_d = frame_start_i;
          rr_ptr_d     = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      frame_pend_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_x_q      <= '0;
      cmd_y_q      <= '0;
      cmd_spr_q    <= '0;
      cmd_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      frame_pend_q <= frame_pend_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_x_q      <= cmd_x_d;
      cmd_y_q      <= cmd_y_d;
      cmd_spr_q    <= cmd_spr_d;
      cmd_src_q    <= cmd_src_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_x_o     = cmd_x_q;
  assign cmd_y_o     = cmd_y_q;
  assign cmd_spr_o   = cmd_spr_q;
  assign cmd_src_o   = cmd_src_q;
  assign busy_o      = (state_q != ST_IDLE) || cmd_valid_q;

endmodule

// File: tb/tb_gpu_draw_arbiter.sv
// Scoreboard bench for gpu_draw_arbiter: requester queues drive beats, expected commands are
// queued in arbitration order and compared at each GPU handshake.
module tb_gpu_draw_arbiter;
  import gpu_pkg::*;

  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int SW = 6;

  typedef struct packed {
    logic [1:0] src;
    draw_cmd_t  c;
  } sb_t;

  typedef struct packed {
    draw_cmd_t c;
    logic      last;
  } beat_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_last_i, req_ready_o;
  logic [N*XW-1:0] req_x_i;
  logic [N*YW-1:0] req_y_i;
  logic [N*SW-1:0] req_spr_i;
  logic            cmd_valid_o, cmd_ready_i, frame_start_i, frame_done_o, busy_o;
  logic [XW-1:0]   cmd_x_o;
  logic [YW-1:0]   cmd_y_o;
  logic [SW-1:0]   cmd_spr_o;
  logic [1:0]      cmd_src_o;

  gpu_draw_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .SPR_W(SW), .MAX_BURST(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .req_spr_i(req_spr_i),
    .req_ready_o(req_ready_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_x_o(cmd_x_o), .cmd_y_o(cmd_y_o), .cmd_spr_o(cmd_spr_o), .cmd_src_o(cmd_src_o),
    .frame_start_i(frame_start_i), .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t rq[N][$];
  sb_t   sb[$];
  int    acc_src_q[$], acc_cyc_q[$], out_cyc_q[$];
  int    vrise[N];
  int    cyc, fd_cnt, fd_cyc, n_cmp, n_err, stall_cnt, stall_seen, seq;
  logic  stall_prev;
  logic [28:0] prev_fields;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mk(input int i, input logic last, output draw_cmd_t c);
    beat_t b;
    seq++;
    c.x   = 11'(seq * 37 + i);
    c.y   = 10'(seq * 13 + 5);
    c.spr = 6'(seq);
    b.c    = c;
    b.last = last;
    rq[i].push_back(b);
  endtask

  task automatic exp_cmd(input int i, input draw_cmd_t c);
    sb_t e;
    e.src = 2'(i);
    e.c   = c;
    sb.push_back(e);
  endtask

  task automatic clear_logs();
    acc_src_q.delete();
    acc_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      @(posedge clk_i); #1;
      n++;
      done = (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) &&
             (rq[3].size() == 0) && (sb.size() == 0) && !busy_o;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int k = 0;
    while (acc_cyc_q.size() < n && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (acc_cyc_q.size() < n) chk({tag, "_acc_timeout"}, 0, 1);
  endtask

  // Driver (negedge) and monitor (just before posedge), one process so ordering is fixed.
  initial begin
    forever begin
      @(negedge clk_i);
      cmd_ready_i = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          if (!req_valid_i[i]) vrise[i] = cyc + 1;
          req_valid_i[i]          = 1'b1;
          req_last_i[i]           = rq[i][0].last;
          req_x_i[i*XW +: XW]     = rq[i][0].c.x;
          req_y_i[i*YW +: YW]     = rq[i][0].c.y;
          req_spr_i[i*SW +: SW]   = rq[i][0].c.spr;
        end else begin
          req_valid_i[i] = 1'b0;
          req_last_i[i]  = 1'b0;
        end
      end
      #4;
      cyc++;
      if (!rst_i) begin
        chk("rdy_onehot", 64'($countones(req_ready_o) <= 1), 1);
        for (int i = 0; i < N; i++) begin
          if (req_valid_i[i] && req_ready_o[i]) begin
            void'(rq[i].pop_front());
            acc_src_q.push_back(i);
            acc_cyc_q.push_back(cyc);
          end
        end
        if (cmd_valid_o && !cmd_ready_i) begin
          stall_seen++;
          chk("stall_rdy", req_ready_o, 0);
          if (stall_prev) chk("hold", {cmd_x_o, cmd_y_o, cmd_spr_o, cmd_src_o}, prev_fields);
        end
        if (cmd_valid_o && cmd_ready_i) begin
          if (sb.size() == 0) chk("sb_extra", 1, 0);
          else chk("cmd", {cmd_src_o, cmd_x_o, cmd_y_o, cmd_spr_o}, sb.pop_front());
          out_cyc_q.push_back(cyc);
        end
        if (frame_done_o) begin
          fd_cnt++;
          fd_cyc = cyc;
          chk("fd_cmdv", cmd_valid_o, 0);
        end
        stall_prev  = cmd_valid_o && !cmd_ready_i;
        prev_fields = {cmd_x_o, cmd_y_o, cmd_spr_o, cmd_src_o};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    draw_cmd_t c, c2;
    draw_cmd_t b1[12];
    int fd0;
    rst_i = 1'b1; req_valid_i = '0; req_last_i = '0; req_x_i = '0; req_y_i = '0; req_spr_i = '0;
    cmd_ready_i = 1'b1; frame_start_i = 1'b0;
    cyc = 0; fd_cnt = 0; fd_cyc = 0; n_cmp = 0; n_err = 0; stall_cnt = 0; stall_seen = 0; seq = 0;
    stall_prev = 1'b0; prev_fields = '0;
    for (int i = 0; i < N; i++) vrise[i] = 0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out", {req_ready_o, cmd_valid_o, cmd_x_o, cmd_y_o, cmd_spr_o, cmd_src_o, frame_done_o, busy_o}, 0);
    @(negedge clk_i); #1 rst_i = 1'b0;

    // T1: single requester, three beats
    @(posedge clk_i); #1;
    clear_logs();
    for (int k = 0; k < 3; k++) begin mk(2, k == 2, c); exp_cmd(2, c); end
    wait_drain("t1", 60);
    chk("t1_n", acc_cyc_q.size(), 3);
    chk("t1_grant_lat", acc_cyc_q[0] - vrise[2], 1);
    chk("t1_consec", acc_cyc_q[2] - acc_cyc_q[0], 2);
    for (int k = 0; k < 3; k++) chk("t1_out_lat", out_cyc_q[k] - acc_cyc_q[k], 1);
    chk("t1_rr_ptr", dut.rr_ptr_q, 3);

    // T2: frame close from idle resets the pointer, then full rotation
    fd0 = fd_cnt;
    @(negedge clk_i); #1 frame_start_i = 1'b1;
    @(negedge clk_i); #1 frame_start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("t2_fd_idle", fd_cnt - fd0, 1);
    clear_logs();
    mk(0, 1'b1, c); exp_cmd(0, c);
    mk(0, 1'b1, c2);
    for (int i = 1; i < N; i++) begin mk(i, 1'b1, c); exp_cmd(i, c); end
    exp_cmd(0, c2);
    wait_drain("t2", 100);
    chk("t2_n", acc_cyc_q.size(), 5);
    for (int k = 1; k < 5; k++) chk("t2_bubble", acc_cyc_q[k] - acc_cyc_q[k-1], 2);

    // T3: burst cap at MAX_BURST with a competing requester
    clear_logs();
    for (int k = 0; k < 12; k++) mk(1, k == 11, b1[k]);
    mk(2, 1'b1, c);
    for (int k = 0; k < 8; k++) exp_cmd(1, b1[k]);
    exp_cmd(2, c);
    for (int k = 8; k < 12; k++) exp_cmd(1, b1[k]);
    wait_drain("t3", 200);
    chk("t3_n", acc_cyc_q.size(), 13);
    chk("t3_break", acc_cyc_q[8] - acc_cyc_q[7], 2);
    chk("t3_resume", acc_cyc_q[9] - acc_cyc_q[8], 2);

    // T4: GPU back-pressure for five cycles mid-burst
    clear_logs();
    stall_seen = 0;
    for (int k = 0; k < 4; k++) begin mk(0, k == 3, c); exp_cmd(0, c); end
    wait_acc("t4", 1, 20);
    stall_cnt = 5;
    wait_drain("t4", 100);
    chk("t4_stalls", stall_seen, 5);
    chk("t4_n", acc_cyc_q.size(), 4);

    // T5: two frame_starts during a burst; drain, single ack, restart at requester 0
    clear_logs();
    fd0 = fd_cnt;
    for (int k = 0; k < 4; k++) begin mk(1, k == 3, c); exp_cmd(1, c); end
    wait_acc("t5", 1, 20);
    @(negedge clk_i); #1 frame_start_i = 1'b1;
    mk(2, 1'b1, c2);
    mk(0, 1'b1, c);
    exp_cmd(0, c);
    exp_cmd(2, c2);
    @(negedge clk_i); #1 frame_start_i = 1'b0;
    @(negedge clk_i); #1 frame_start_i = 1'b1;
    @(negedge clk_i); #1 frame_start_i = 1'b0;
    wait_drain("t5", 100);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t5_n", acc_cyc_q.size(), 6);
    chk("t5_fd_once", fd_cnt - fd0, 1);
    chk("t5_fd_after_out", 64'(fd_cyc > out_cyc_q[3]), 1);
    chk("t5_fd_before_next", 64'(fd_cyc < acc_cyc_q[4]), 1);
    chk("t5_next_src", acc_src_q[4], 0);

    // T6: synchronous reset mid-burst with a command pending
    clear_logs();
    for (int k = 0; k < 8; k++) begin mk(2, k == 7, c); exp_cmd(2, c); end
    wait_acc("t6", 2, 20);
    chk("t6_pre_cv", cmd_valid_o, 1);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    rq[2].delete();
    sb.delete();
    req_valid_i = '0;
    req_last_i  = '0;
    @(posedge clk_i); #1;
    chk("t6_rst_out", {req_ready_o, cmd_valid_o, cmd_x_o, cmd_y_o, cmd_spr_o, cmd_src_o, frame_done_o, busy_o}, 0);
    chk("t6_state", dut.state_q, ST_IDLE);
    chk("t6_rr_ptr", dut.rr_ptr_q, 0);
    @(negedge clk_i); #1 rst_i = 1'b0;

    // T7: arbiter serves normally after reset
    clear_logs();
    mk(1, 1'b1, c); exp_cmd(1, c);
    wait_drain("t7", 40);
    chk("t7_n", acc_cyc_q.size(), 1);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
